// File: rtl/posit_decoder_param_pkg.sv
// Shared definitions for the posit decoder: FSM states and width helpers.
package posit_decoder_param_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SCAN,
    S_EXTRACT,
    S_DONE
  } state_e;

  // Width of the signed regime value k.
  function automatic int kw_of(input int n);
    return $clog2(n) + 1;
  endfunction

  // Width of the run-length counter m (holds up to n-1).
  function automatic int mw_of(input int n);
    return $clog2(n);
  endfunction

  // exp_value keeps one bit when ES=0 so the port never collapses to zero width.
  function automatic int ew_of(input int es);
    return (es > 0) ? es : 1;
  endfunction

endpackage

// File: rtl/posit_regime_scan.sv
// Regime run-length finder. Serial one-bit-per-cycle counter by default;
// POSIT_DEC_FAST_LZC_EN swaps in a single-cycle combinational leading-run counter.
module posit_regime_scan
  import posit_decoder_param_pkg::*;
#(
  parameter  int N  = 32,
  localparam int MW = mw_of(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-2:0]  word,
  input  logic          start_scan,
  input  logic          scan_en,
  output logic [MW-1:0] m,
  output logic          run_bit,
  output logic          scan_done
);

  assign run_bit = word[N-2];

`ifdef POSIT_DEC_FAST_LZC_EN
  logic [MW-1:0] len;
  logic          in_run;

  always_comb begin
    len    = '0;
    in_run = 1'b1;
    for (int i = N - 2; i >= 0; i--) begin
      if (in_run && (word[i] == run_bit)) len = len + MW'(1);
      else                                in_run = 1'b0;
    end
  end

  assign m         = len;
  assign scan_done = scan_en;
`else
  logic [MW-1:0] cnt_q, cnt_d;
  logic [MW-1:0] idx;
  logic          cur_bit;

  // cnt_q bits of the run are already counted; look at the next one down.
  assign idx       = MW'(N - 2) - cnt_q;
  assign cur_bit   = (cnt_q == MW'(N - 1)) ? run_bit : word[idx];
  assign scan_done = scan_en && ((cnt_q == MW'(N - 1)) || (cur_bit != run_bit));

  always_comb begin
    cnt_d = cnt_q;
    if (start_scan)                  cnt_d = MW'(1);
    else if (scan_en && !scan_done)  cnt_d = cnt_q + MW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign m = cnt_q;
`endif

endmodule

// File: rtl/posit_decoder_param.sv
// Multi-cycle posit<N,ES> decoder with start/done/received handshake.
// Define POSIT_DEC_FAST_LZC_EN for a single-cycle regime scan.
module posit_decoder_param
  import posit_decoder_param_pkg::*;
#(
  parameter  int N  = 32,
  parameter  int ES = 3,
  localparam int KW = kw_of(N),
  localparam int EW = ew_of(ES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         posit_num,
  input  logic                 start,
  input  logic                 received,
  output logic                 sign,
  output logic                 done,
  output logic                 ZERO,
  output logic                 NAR,
  output logic signed [KW-1:0] k,
  output logic [EW-1:0]        exp_value,
  output logic [N-1:0]         mantissa
);

  localparam int MW = mw_of(N);
  localparam logic [N-1:0] NAR_PAT = {1'b1, {(N-1){1'b0}}};

  state_e        state_q, state_d;
  logic          armed_q, armed_d;
  logic [N-1:0]  word_q, word_d;
  logic [MW-1:0] m_q, m_d;
  logic          sign_q, sign_d, done_q, done_d, zero_q, zero_d, nar_q, nar_d;
  logic [KW-1:0] k_q, k_d;
  logic [EW-1:0] exp_q, exp_d;
  logic [N-1:0]  mant_q, mant_d;
  logic [N-1:0]  tail;

  logic [MW-1:0] scan_m;
  logic          scan_run, scan_done;

  posit_regime_scan #(.N(N)) u_scan (
    .clk       (clk),
    .rst       (rst),
    .word      (word_q[N-2:0]),
    .start_scan(state_q == S_LOAD),
    .scan_en   (state_q == S_SCAN),
    .m         (scan_m),
    .run_bit   (scan_run),
    .scan_done (scan_done)
  );

  always_comb begin
    state_d = state_q;
    armed_d = start ? armed_q : 1'b1;
    word_d  = word_q;
    m_d     = m_q;
    sign_d  = sign_q;
    done_d  = done_q;
    zero_d  = zero_q;
    nar_d   = nar_q;
    k_d     = k_q;
    exp_d   = exp_q;
    mant_d  = mant_q;
    tail    = '0;
    case (state_q)
      S_IDLE: begin
        if (start && armed_q) begin
          word_d  = posit_num;
          armed_d = 1'b0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        sign_d = word_q[N-1];
        zero_d = (word_q == '0);
        nar_d  = (word_q == NAR_PAT);
        k_d    = '0;
        exp_d  = '0;
        mant_d = '0;
        if (zero_d || nar_d) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          word_d  = word_q[N-1] ? (N'(0) - word_q) : word_q;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (scan_done) begin
          m_d     = scan_m;
          k_d     = scan_run ? ({1'b0, scan_m} - KW'(1)) : (KW'(0) - {1'b0, scan_m});
          state_d = S_EXTRACT;
        end
      end
      S_EXTRACT: begin
        // Drop sign, run and terminator; shifting past the word yields the zero fill.
        tail    = word_q << (int'(m_q) + 2);
        exp_d   = (ES > 0) ? EW'(tail >> (N - EW)) : '0;
        mant_d  = N'({1'b1, tail << ES} >> 1);
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (received) begin
          done_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      armed_q <= 1'b1;
      word_q  <= '0;
      m_q     <= '0;
      sign_q  <= 1'b0;
      done_q  <= 1'b0;
      zero_q  <= 1'b0;
      nar_q   <= 1'b0;
      k_q     <= '0;
      exp_q   <= '0;
      mant_q  <= '0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      word_q  <= word_d;
      m_q     <= m_d;
      sign_q  <= sign_d;
      done_q  <= done_d;
      zero_q  <= zero_d;
      nar_q   <= nar_d;
      k_q     <= k_d;
      exp_q   <= exp_d;
      mant_q  <= mant_d;
    end
  end

  assign sign      = sign_q;
  assign done      = done_q;
  assign ZERO      = zero_q;
  assign NAR       = nar_q;
  assign k         = k_q;
  assign exp_value = exp_q;
  assign mantissa  = mant_q;

endmodule

// File: tb/tb_posit_decoder_param.sv
// Self-checking bench for posit_decoder_param (N=32, ES=3) against a bit-walking reference decoder.
module tb_posit_decoder_param;
  localparam int N  = 32;
  localparam int ES = 3;
  localparam int KW = $clog2(N) + 1;
  localparam int OW = 3 + KW + ES + N;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [N-1:0]         posit_num = '0;
  logic                 start = 1'b0;
  logic                 received = 1'b0;
  logic                 sign, done, ZERO, NAR;
  logic signed [KW-1:0] k;
  logic [ES-1:0]        exp_value;
  logic [N-1:0]         mantissa;

  int total = 0;
  int bad   = 0;

  posit_decoder_param #(.N(N), .ES(ES)) dut (
    .clk(clk), .rst(rst), .posit_num(posit_num), .start(start), .received(received),
    .sign(sign), .done(done), .ZERO(ZERO), .NAR(NAR), .k(k),
    .exp_value(exp_value), .mantissa(mantissa)
  );

  always #5 clk = ~clk;

  // Reference: walk the bit string field by field; returns {sign,ZERO,NAR,k,exp,mantissa}.
  function automatic logic [OW-1:0] ref_decode(input logic [N-1:0] w, output int lat);
    logic s, r;
    logic [N-1:0] a, mant;
    logic [ES-1:0] e;
    int m, idx, pos, kk;
    s = w[N-1];
    if (w == '0 || w == {1'b1, {(N-1){1'b0}}}) begin
      lat = 1;
      return {s, (w == '0), (w != '0), {KW{1'b0}}, {ES{1'b0}}, {N{1'b0}}};
    end
    a = s ? (N'(0) - w) : w;
    r = a[N-2];
    m = 0;
    idx = N - 2;
    while (idx >= 0 && a[idx] == r) begin m++; idx--; end
    kk = r ? m - 1 : -m;
    if (idx >= 0) idx--;
    e = '0;
    for (int j = 0; j < ES; j++) begin
      e = {e[ES-2:0], (idx >= 0) ? a[idx] : 1'b0};
      idx--;
    end
    mant = '0;
    mant[N-1] = 1'b1;
    pos = N - 2;
    while (idx >= 0) begin mant[pos] = a[idx]; pos--; idx--; end
`ifdef POSIT_DEC_FAST_LZC_EN
    lat = 3;
`else
    lat = 2 + m;
`endif
    return {s, 1'b0, 1'b0, KW'(kk), e, mant};
  endfunction

  task automatic run_decode(input logic [N-1:0] w, input bit keep_start,
                            output logic [OW-1:0] obs, output int lat);
    posit_num = w;
    start = 1'b1;
    @(posedge clk); #1;
    if (!keep_start) start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    obs = {sign, ZERO, NAR, k, exp_value, mantissa};
  endtask

  task automatic ack();
    received = 1'b1;
    @(posedge clk); #1;
    received = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({sign, done, ZERO, NAR, k, exp_value, mantissa} !== '0) begin
      bad++;
      $display("FAIL reset outputs: got %h want 0", {sign, done, ZERO, NAR, k, exp_value, mantissa});
    end
    rst = 1'b1;
  endtask

  task automatic test_directed();
    logic [N-1:0]  vec  [7];
    logic [OW-1:0] want [7];
    logic [OW-1:0] obs, dummy;
    int lat, lat_ref;
    vec[0] = 32'h80000000; want[0] = {1'b1, 1'b0, 1'b1, KW'(0),   3'b000, 32'h00000000};
    vec[1] = 32'h00000000; want[1] = {1'b0, 1'b1, 1'b0, KW'(0),   3'b000, 32'h00000000};
    vec[2] = 32'h48000000; want[2] = {1'b0, 1'b0, 1'b0, KW'(0),   3'b010, 32'h80000000};
    vec[3] = 32'hC0000000; want[3] = {1'b1, 1'b0, 1'b0, KW'(0),   3'b000, 32'h80000000};
    vec[4] = 32'h40100000; want[4] = {1'b0, 1'b0, 1'b0, KW'(0),   3'b000, 32'h82000000};
    vec[5] = 32'h7FFFFFFF; want[5] = {1'b0, 1'b0, 1'b0, KW'(30),  3'b000, 32'h80000000};
    vec[6] = 32'h00000001; want[6] = {1'b0, 1'b0, 1'b0, KW'(-30), 3'b000, 32'h80000000};
    for (int i = 0; i < 7; i++) begin
      dummy = ref_decode(vec[i], lat_ref);
      run_decode(vec[i], 1'b0, obs, lat);
      total++;
      if (obs !== want[i]) begin
        bad++;
        $display("FAIL directed[%0d] fields: got %h want %h", i, obs, want[i]);
      end
      total++;
      if (lat != lat_ref) begin
        bad++;
        $display("FAIL directed[%0d] latency: got %0d want %0d", i, lat, lat_ref);
      end
      ack();
      total++;
      if (done !== 1'b0) begin
        bad++;
        $display("FAIL directed[%0d] done after ack: got %b want 0", i, done);
      end
    end
  endtask

  task automatic test_random();
    logic [N-1:0]  w;
    logic [OW-1:0] obs, exp_o;
    int lat, lat_ref;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 2))
        0:       w = $urandom;
        1:       w = $urandom >> $urandom_range(0, N - 1);
        default: w = ~($urandom >> $urandom_range(0, N - 1));
      endcase
      if ($urandom_range(0, 1) == 1) w[N-1] = ~w[N-1];
      exp_o = ref_decode(w, lat_ref);
      run_decode(w, 1'b0, obs, lat);
      total++;
      if (obs !== exp_o) begin
        bad++;
        $display("FAIL random %h fields: got %h want %h", w, obs, exp_o);
      end
      total++;
      if (lat != lat_ref) begin
        bad++;
        $display("FAIL random %h latency: got %0d want %0d", w, lat, lat_ref);
      end
      ack();
    end
  endtask

  task automatic test_received_early();
    logic [OW-1:0] obs, exp_o;
    int lat, lat_ref;
    exp_o = ref_decode(32'h00000007, lat_ref);
    received = 1'b1;
    run_decode(32'h00000007, 1'b0, obs, lat);
    total++;
    if (obs !== exp_o) begin
      bad++;
      $display("FAIL early_received fields: got %h want %h", obs, exp_o);
    end
    total++;
    if (lat != lat_ref) begin
      bad++;
      $display("FAIL early_received latency: got %0d want %0d", lat, lat_ref);
    end
    @(posedge clk); #1;
    received = 1'b0;
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL early_received done release: got %b want 0", done);
    end
  endtask

  task automatic test_hold_start();
    logic [OW-1:0] obs, exp_o;
    int lat, lat_ref, seen;
    exp_o = ref_decode(32'h48000000, lat_ref);
    run_decode(32'h48000000, 1'b1, obs, lat);
    total++;
    if (obs !== exp_o) begin
      bad++;
      $display("FAIL hold_start fields: got %h want %h", obs, exp_o);
    end
    ack();
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL hold_start redecode: got %0d done cycles want 0", seen);
    end
    start = 1'b0;
    @(posedge clk); #1;
    exp_o = ref_decode(32'hB3C0FFEE, lat_ref);
    run_decode(32'hB3C0FFEE, 1'b0, obs, lat);
    total++;
    if (obs !== exp_o) begin
      bad++;
      $display("FAIL hold_start rearm: got %h want %h", obs, exp_o);
    end
    ack();
  endtask

  task automatic test_reset_midscan();
    logic [OW-1:0] obs, exp_o;
    int lat, lat_ref, seen;
    posit_num = 32'hFFFFFFFF;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({sign, done, ZERO, NAR, k, exp_value, mantissa} !== '0) begin
      bad++;
      $display("FAIL midscan reset: got %h want 0", {sign, done, ZERO, NAR, k, exp_value, mantissa});
    end
    rst = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL midscan abort: got %0d done cycles want 0", seen);
    end
    exp_o = ref_decode(32'h9A000001, lat_ref);
    run_decode(32'h9A000001, 1'b0, obs, lat);
    total++;
    if (obs !== exp_o) begin
      bad++;
      $display("FAIL midscan recovery: got %h want %h", obs, exp_o);
    end
    ack();
  endtask

  task automatic test_back_to_back();
    logic [N-1:0]  w;
    logic [OW-1:0] obs, exp_o;
    int lat, lat_ref;
    for (int i = 0; i < 8; i++) begin
      w = $urandom;
      exp_o = ref_decode(w, lat_ref);
      run_decode(w, 1'b0, obs, lat);
      total++;
      if (obs !== exp_o || lat != lat_ref) begin
        bad++;
        $display("FAIL b2b %h: got %h lat %0d want %h lat %0d", w, obs, lat, exp_o, lat_ref);
      end
      ack();
      total++;
      if ({done, sign, ZERO, NAR, k, exp_value, mantissa} !== {1'b0, exp_o}) begin
        bad++;
        $display("FAIL b2b hold %h: got %h want %h", w,
                 {done, sign, ZERO, NAR, k, exp_value, mantissa}, {1'b0, exp_o});
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_received_early();
    test_hold_start();
    test_reset_midscan();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
